mant_norm_stage: RTL and testbench

- Post-add normalization stage of the FPU add/sub path; inverse of mantissa alignment.
- Takes the raw signed-magnitude mantissa sum with its common exponent and shifts it back to the 1.f form:
  - right 1 on carry-out;
  - left, one bit per cycle, after cancellation.
- Adjusts the exponent, detects zero, overflow and underflow, rounds, then hands the packed result downstream over a valid/ready handshake.

---
 rtl/mant_norm_if.sv | 48 ++++
 rtl/mant_norm_stage.sv | 178 +++++++++++++++++
 tb/tb_mant_norm_stage.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mant_norm_if.sv
// -----------------------------------------------------------------------------
// mant_norm_if
// Bundles the operand and result channels of mant_norm_stage.
//
// Valid/ready handshake, used on both channels:
//   A transfer happens on a rising clock edge where valid and ready are both 1.
//   After raising valid, the producer holds valid and its payload stable until
//   that transfer. The consumer may change ready at any time. There is no
//   combinational path from valid to ready or from ready to valid.
//
// Operand channel (upstream -> stage):
//   valid_i, ready_o, sign_i, exp_i, sum_i, grs_i
// Result channel (stage -> downstream):
//   valid_o, ready_i, sign_o, exp_o, mant_o, ovf_o, uf_o
//
// Modports:
//   slave  : the normalization stage
//   master : the environment that drives operands and consumes results
// -----------------------------------------------------------------------------
interface mant_norm_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic              valid_i;
    logic              ready_o;
    logic              sign_i;
    logic [EXP_W-1:0]  exp_i;
    logic [MANT_W+1:0] sum_i;
    logic [2:0]        grs_i;

    logic              valid_o;
    logic              ready_i;
    logic              sign_o;
    logic [EXP_W-1:0]  exp_o;
    logic [MANT_W-1:0] mant_o;
    logic              ovf_o;
    logic              uf_o;

    modport slave (
        input  valid_i, sign_i, exp_i, sum_i, grs_i, ready_i,
        output ready_o, valid_o, sign_o, exp_o, mant_o, ovf_o, uf_o
    );

    modport master (
        output valid_i, sign_i, exp_i, sum_i, grs_i, ready_i,
        input  ready_o, valid_o, sign_o, exp_o, mant_o, ovf_o, uf_o
    );
endinterface

// File: rtl/mant_norm_stage.sv
// -----------------------------------------------------------------------------
// mant_norm_stage
// Post-add normalization for the FPU add/sub path. Takes the raw mantissa sum
// and the common exponent, renormalizes to 1.f form (one right shift on carry
// out, left shifts one bit per cycle after cancellation), adjusts the exponent,
// flags zero/overflow/underflow, rounds and presents the packed result.
//
// Ports:
//   clk_i    clock
//   rst_i    asynchronous reset, active-high
//   bus      mant_norm_if.slave: operand channel (valid_i/ready_o, sign_i,
//            exp_i, sum_i, grs_i) and result channel (valid_o/ready_i, sign_o,
//            exp_o, mant_o, ovf_o, uf_o). All outputs are registered.
//   state_o  current FSM state (IDLE=0, NORM=1, ROUND=2, DONE=3), debug only
//
// Build option:
//   ROUND_NEAREST_EN  defined   -> round-to-nearest-even using G/R/S
//                     undefined -> truncation (G/R/S discarded)
//   ROUND takes one cycle in both builds, so latency does not change.
// -----------------------------------------------------------------------------
module mant_norm_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mant_norm_if.slave  bus,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Work register layout: {carry, hidden, frac[MANT_W-1:0], G, R, S}
    localparam int MW  = MANT_W + 5;
    localparam int C_B = MW - 1;
    localparam int H_B = MW - 2;
    localparam logic [EXP_W-1:0] E_MAX = '1;
    localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

    state_t            state_q;
    logic [MW-1:0]     m_q;
    logic [EXP_W-1:0]  e_q;
    logic              sign_q;
    logic              ovf_q;
    logic              uf_q;
    logic              skip_q;   // special or overflowed result: bypass rounding

    logic [EXP_W-1:0]  e_inc;
    logic              inc;
    logic [MANT_W+1:0] rnd_sum;  // {carry, hidden, frac} after the increment

    always_comb begin
        e_inc = e_q + E_ONE;
`ifdef ROUND_NEAREST_EN
        // Nearest-even: round up above half, or at exactly half with odd LSB.
        inc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
`else
        inc = 1'b0;
`endif
        rnd_sum = m_q[MW-1:3] + {{(MANT_W+1){1'b0}}, inc};
    end

    assign state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            m_q         <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            uf_q        <= 1'b0;
            skip_q      <= 1'b0;
            bus.ready_o <= 1'b1;
            bus.valid_o <= 1'b0;
            bus.sign_o  <= 1'b0;
            bus.exp_o   <= '0;
            bus.mant_o  <= '0;
            bus.ovf_o   <= 1'b0;
            bus.uf_o    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_i && bus.ready_o) begin
                        m_q         <= {bus.sum_i, bus.grs_i};
                        e_q         <= bus.exp_i;
                        sign_q      <= bus.sign_i;
                        ovf_q       <= 1'b0;
                        uf_q        <= 1'b0;
                        skip_q      <= 1'b0;
                        bus.ready_o <= 1'b0;
                        state_q     <= NORM;
                    end
                end

                NORM: begin
                    if (e_q == E_MAX) begin
                        // Inf/NaN operand: pass through untouched.
                        skip_q  <= 1'b1;
                        state_q <= ROUND;
                    end else if (m_q == '0) begin
                        e_q     <= '0;
                        state_q <= ROUND;
                    end else if (m_q[C_B]) begin
                        // Right shift; the bit leaving S folds into the sticky.
                        e_q <= e_inc;
                        if (e_inc == E_MAX) begin
                            ovf_q   <= 1'b1;
                            skip_q  <= 1'b1;
                            m_q     <= '0;
                            state_q <= ROUND;
                        end else begin
                            m_q <= {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                        end
                    end else if (m_q[H_B]) begin
                        state_q <= ROUND;
                    end else if (e_q > E_ONE) begin
                        m_q <= {m_q[MW-2:0], 1'b0};
                        e_q <= e_q - E_ONE;
                    end else begin
                        // Exponent exhausted: keep the fraction as a denormal.
                        e_q     <= '0;
                        uf_q    <= 1'b1;
                        state_q <= ROUND;
                    end
                end

                ROUND: begin
                    bus.sign_o <= sign_q;
                    if (skip_q || !inc) begin
                        bus.exp_o  <= e_q;
                        bus.mant_o <= m_q[MANT_W+2:3];
                        bus.ovf_o  <= ovf_q;
                        bus.uf_o   <= uf_q;
                    end else if (rnd_sum[MANT_W+1]) begin
                        // Increment rippled into the carry: renormalize right.
                        bus.exp_o <= e_inc;
                        bus.uf_o  <= uf_q;
                        if (e_inc == E_MAX) begin
                            bus.ovf_o  <= 1'b1;
                            bus.mant_o <= '0;
                        end else begin
                            bus.ovf_o  <= ovf_q;
                            bus.mant_o <= rnd_sum[MANT_W:1];
                        end
                    end else begin
                        bus.mant_o <= rnd_sum[MANT_W-1:0];
                        bus.ovf_o  <= ovf_q;
                        if (e_q == '0 && rnd_sum[MANT_W]) begin
                            // Denormal rounded up into the smallest normal.
                            bus.exp_o <= E_ONE;
                            bus.uf_o  <= 1'b0;
                        end else begin
                            bus.exp_o <= e_q;
                            bus.uf_o  <= uf_q;
                        end
                    end
                    bus.valid_o <= 1'b1;
                    state_q     <= DONE;
                end

                DONE: begin
                    if (bus.ready_i) begin
                        bus.valid_o <= 1'b0;
                        bus.ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mant_norm_stage.sv
// -----------------------------------------------------------------------------
// tb_mant_norm_stage
// Self-checking bench for mant_norm_stage: reset values, a table of directed
// vectors, a reset-during-normalize sequence, and randomized operands compared
// against an arithmetic reference model. Build with +define+ROUND_NEAREST_EN
// to check the rounding build.
// -----------------------------------------------------------------------------
module tb_mant_norm_stage;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SW     = MANT_W + 2;
    localparam int EMAX   = (1 << EXP_W) - 1;
    localparam int HB     = MANT_W + 3;   // hidden-bit index in the 28-bit work value

    logic       clk;
    logic       rst_i;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    mant_norm_if #(.EXP_W(EXP_W), .MANT_W(MANT_W)) bus ();

    mant_norm_stage #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- types ----------------
    typedef struct {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SW-1:0]     sum;
        logic [2:0]        grs;
        logic [EXP_W-1:0]  x_exp;
        logic [MANT_W-1:0] x_mant;
        logic              x_ovf;
        logic              x_uf;
        int                x_lat;
    } vec_t;

    typedef struct {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              ovf;
        logic              uf;
        int                lat;
    } res_t;

    vec_t vecs[7];

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: find the leading one and compute the whole shift at
    // once, limited by how far the exponent can go down.
    function automatic res_t model(input logic [EXP_W-1:0] e_in, input logic [SW-1:0] sm,
                                   input logic [2:0] grs);
        res_t r;
        logic [MANT_W+4:0] m;
        logic [MANT_W+1:0] v;
        int e, p, need, avail, n;
        bit g, rr, s, lsb;
        m = {sm, grs};
        e = int'(e_in);
        r.ovf = 1'b0;
        r.uf  = 1'b0;
        r.lat = 2;
        if (e == EMAX) begin
            r.exp  = e_in;
            r.mant = sm[MANT_W-1:0];
            return r;
        end
        if (m == '0) begin
            r.exp  = '0;
            r.mant = '0;
            return r;
        end
        n = 0;
        if (m[HB+1]) begin
            m = (m >> 1) | {{(MANT_W+4){1'b0}}, m[0]};
            e = e + 1;
            n = 1;
            if (e == EMAX) begin
                r.exp  = EXP_W'(EMAX);
                r.mant = '0;
                r.ovf  = 1'b1;
                return r;
            end
        end else begin
            p = 0;
            for (int i = HB; i >= 0; i--) begin
                if (m[i]) begin
                    p = i;
                    break;
                end
            end
            need  = HB - p;
            avail = (e > 1) ? e - 1 : 0;
            if (need <= avail) begin
                m = m << need;
                e = e - need;
                n = need;
            end else begin
                m = m << avail;
                n = avail;
                e = 0;
                r.uf = 1'b1;
            end
        end
        r.lat = n + 2;
        v = m[MANT_W+4:3];
        g = m[2]; rr = m[1]; s = m[0]; lsb = m[3];
`ifdef ROUND_NEAREST_EN
        if (g && (rr || s || lsb)) begin
            v = v + 1'b1;
            if (v[MANT_W+1]) begin
                v = v >> 1;
                e = e + 1;
                if (e == EMAX) begin
                    r.exp  = EXP_W'(EMAX);
                    r.mant = '0;
                    r.ovf  = 1'b1;
                    return r;
                end
            end else if (e == 0 && v[MANT_W]) begin
                e = 1;
                r.uf = 1'b0;
            end
        end
`else
        if (g && rr && s && lsb) v = v;  // rounding bits ignored in truncation
`endif
        r.exp  = EXP_W'(e);
        r.mant = v[MANT_W-1:0];
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic s, input logic [EXP_W-1:0] e, input logic [SW-1:0] sm,
                          input logic [2:0] g, input logic [EXP_W-1:0] xe,
                          input logic [MANT_W-1:0] xm, input logic xo, input logic xu,
                          input int xl, input int hold, input bit noise);
        int wc;
        int lat;
        wc = 0;
        while (!bus.ready_o && wc < 200) begin
            @(negedge clk);
            wc++;
        end
        chk("ready_before_op", 32'(bus.ready_o), 32'd1);
        bus.sign_i  = s;
        bus.exp_i   = e;
        bus.sum_i   = sm;
        bus.grs_i   = g;
        bus.valid_i = 1'b1;
        @(negedge clk);
        chk("ready_low_busy", 32'(bus.ready_o), 32'd0);
        bus.valid_i = noise;
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            if (noise) begin
                bus.sign_i = 1'($urandom);
                bus.exp_i  = EXP_W'($urandom);
                bus.sum_i  = SW'($urandom);
                bus.grs_i  = 3'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.valid_i = 1'b0;
        chk("latency", 32'(lat), 32'(xl));
        chk("sign", 32'(bus.sign_o), 32'(s));
        chk("exp", 32'(bus.exp_o), 32'(xe));
        chk("mant", 32'(bus.mant_o), 32'(xm));
        chk("ovf", 32'(bus.ovf_o), 32'(xo));
        chk("uf", 32'(bus.uf_o), 32'(xu));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.valid_o), 32'd1);
            chk("hold_ready", 32'(bus.ready_o), 32'd0);
            chk("hold_exp", 32'(bus.exp_o), 32'(xe));
            chk("hold_mant", 32'(bus.mant_o), 32'(xm));
            chk("hold_flags", {30'd0, bus.ovf_o, bus.uf_o}, {30'd0, xo, xu});
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk("ready_after_hs", 32'(bus.ready_o), 32'd1);
        chk("valid_after_hs", 32'(bus.valid_o), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [SW-1:0]    rs;
        logic [EXP_W-1:0] re;
        logic [2:0]       rg;
        logic             rsg;
        res_t             ref_r;
        int               bad;

        vecs[0] = '{1'b0, 8'h80, {1'b1, 1'b0, 23'h0},      3'b000, 8'h81, 23'h0,      1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 8'h85, {1'b0, 1'b0, 23'h100000}, 3'b000, 8'h82, 23'h0,      1'b0, 1'b0, 5};
        vecs[2] = '{1'b1, 8'h90, 25'h0,                    3'b000, 8'h00, 23'h0,      1'b0, 1'b0, 2};
        vecs[3] = '{1'b0, 8'hFE, {1'b1, 1'b0, 23'h0},      3'b000, 8'hFF, 23'h0,      1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 8'h02, {1'b0, 1'b0, 23'h100000}, 3'b000, 8'h00, 23'h200000, 1'b0, 1'b1, 3};
`ifdef ROUND_NEAREST_EN
        vecs[5] = '{1'b0, 8'h80, {1'b0, 1'b1, 23'h7FFFFF}, 3'b100, 8'h81, 23'h0,      1'b0, 1'b0, 2};
`else
        vecs[5] = '{1'b0, 8'h80, {1'b0, 1'b1, 23'h7FFFFF}, 3'b100, 8'h80, 23'h7FFFFF, 1'b0, 1'b0, 2};
`endif
        vecs[6] = '{1'b1, 8'hFF, {1'b0, 1'b1, 23'h123456}, 3'b000, 8'hFF, 23'h123456, 1'b0, 1'b0, 2};

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.sign_i  = 1'b0;
        bus.exp_i   = '0;
        bus.sum_i   = '0;
        bus.grs_i   = '0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_sign", 32'(bus.sign_o), 32'd0);
        chk("rst_exp", 32'(bus.exp_o), 32'd0);
        chk("rst_mant", 32'(bus.mant_o), 32'd0);
        chk("rst_flags", {30'd0, bus.ovf_o, bus.uf_o}, 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);

        // Directed table; the first vector holds DONE for 10 cycles
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].sign, vecs[i].exp, vecs[i].sum, vecs[i].grs, vecs[i].x_exp,
                   vecs[i].x_mant, vecs[i].x_ovf, vecs[i].x_uf, vecs[i].x_lat,
                   (i == 0) ? 10 : 1, 1'b0);
        end

        // Reset pulsed during a long left-normalization
        bus.sign_i  = 1'b0;
        bus.exp_i   = 8'h80;
        bus.sum_i   = 25'h1;
        bus.grs_i   = 3'b000;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_state_norm", 32'(state_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid_o) bad++;
        end
        chk("rst_mid_no_valid", 32'(bad), 32'd0);
        chk("rst_mid_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_mid_state", 32'(state_o), 32'd0);

        // Randomized operands against the reference model
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 7))
                0:       re = EXP_W'($urandom_range(0, 2));
                1:       re = EXP_W'($urandom_range(EMAX - 2, EMAX));
                default: re = EXP_W'($urandom_range(0, EMAX));
            endcase
            rs  = SW'($urandom) >> $urandom_range(0, SW);
            rg  = 3'($urandom);
            rsg = 1'($urandom);
            ref_r = model(re, rs, rg);
            run_op(rsg, re, rs, rg, ref_r.exp, ref_r.mant, ref_r.ovf, ref_r.uf, ref_r.lat,
                   $urandom_range(0, 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
